// File: rtl/hazard_pkg.sv
// Shared types and constants for the load-use interlock.
package hazard_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, FWD, DRAIN} lh_state_t;

  localparam logic [4:0] REG_X0 = '0;

  // True when a decode operand is read and names the given register.
  function automatic logic src_match(input logic uses, input logic [4:0] src,
                                     input logic [4:0] rd);
    return uses && (src == rd);
  endfunction

endpackage

// File: rtl/load_use_hazard_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != MAX)) begin
      cnt_reg <= cnt_reg + ONE;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/load_use_hazard.sv
// Load-use interlock: stalls decode behind a load in exec until the data
// memory responds, then forwards the load word to the held instruction.
module load_use_hazard
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd_src,
  input  logic             dec_valid,
  input  logic [4:0]       dec_rs1_src,
  input  logic [4:0]       dec_rs2_src,
  input  logic             dec_uses_rs1,
  input  logic             dec_uses_rs2,
  input  logic             flush,
  input  logic             mem_rvalid,
  input  logic [31:0]      mem_rdata,
  output logic             dec_stall,
  output logic             ex_bubble,
  output logic             is_ld_fwd_rs1,
  output logic             is_ld_fwd_rs2,
  output logic [31:0]      ld_fwd_val,
  output logic [CNT_W-1:0] stall_cnt
);

  lh_state_t   state;
  logic [4:0]  ld_rd_q;
  logic [31:0] ld_fwd_val_reg;
  logic        hz;

  // A load writing x0 never creates a dependency, so it is excluded here.
  always_comb begin
    hz = ex_valid && ex_is_load && (ex_rd_src != REG_X0) && dec_valid && !flush &&
         (src_match(dec_uses_rs1, dec_rs1_src, ex_rd_src) ||
          src_match(dec_uses_rs2, dec_rs2_src, ex_rd_src));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      ld_rd_q        <= REG_X0;
      ld_fwd_val_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hz) begin
            ld_rd_q <= ex_rd_src;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid && !flush) begin
            ld_fwd_val_reg <= mem_rdata;
            state          <= FWD;
          end else if (flush && mem_rvalid) begin
            state <= IDLE;
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        FWD: begin
          if (hz) begin
            ld_rd_q <= ex_rd_src;
            state   <= WAIT;
          end else begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          // The redirected load's response is still in flight; swallow it.
          if (mem_rvalid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    dec_stall     = 1'b0;
    ex_bubble     = 1'b0;
    is_ld_fwd_rs1 = 1'b0;
    is_ld_fwd_rs2 = 1'b0;
    case (state)
      IDLE: begin
        dec_stall = hz;
        ex_bubble = hz;
      end
      WAIT, DRAIN: begin
        dec_stall = 1'b1;
        ex_bubble = 1'b1;
      end
      FWD: begin
        dec_stall     = hz;
        ex_bubble     = hz;
        is_ld_fwd_rs1 = dec_valid && !flush && src_match(dec_uses_rs1, dec_rs1_src, ld_rd_q);
        is_ld_fwd_rs2 = dec_valid && !flush && src_match(dec_uses_rs2, dec_rs2_src, ld_rd_q);
      end
      default: begin
        dec_stall = 1'b0;
        ex_bubble = 1'b0;
      end
    endcase
  end

  assign ld_fwd_val = ld_fwd_val_reg;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .inc(dec_stall),
    .cnt(stall_cnt)
  );

endmodule

// File: tb/tb_load_use_hazard.sv
// Directed bench for load_use_hazard with an expectation queue per cycle.
module tb_load_use_hazard;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_is_load;
  logic [4:0]  ex_rd_src;
  logic        dec_valid;
  logic [4:0]  dec_rs1_src;
  logic [4:0]  dec_rs2_src;
  logic        dec_uses_rs1;
  logic        dec_uses_rs2;
  logic        flush;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        dec_stall;
  logic        ex_bubble;
  logic        is_ld_fwd_rs1;
  logic        is_ld_fwd_rs2;
  logic [31:0] ld_fwd_val;
  logic [31:0] stall_cnt;

  load_use_hazard #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd_src(ex_rd_src),
    .dec_valid(dec_valid), .dec_rs1_src(dec_rs1_src), .dec_rs2_src(dec_rs2_src),
    .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2),
    .flush(flush), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dec_stall(dec_stall), .ex_bubble(ex_bubble),
    .is_ld_fwd_rs1(is_ld_fwd_rs1), .is_ld_fwd_rs2(is_ld_fwd_rs2),
    .ld_fwd_val(ld_fwd_val), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic        bubble;
    logic        f1;
    logic        f2;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt = '0;

  task automatic set_in(input logic exv, input logic exl, input logic [4:0] exrd,
                        input logic decv, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic fl,
                        input logic rv, input logic [31:0] rd);
    ex_valid = exv; ex_is_load = exl; ex_rd_src = exrd;
    dec_valid = decv; dec_rs1_src = rs1; dec_rs2_src = rs2;
    dec_uses_rs1 = u1; dec_uses_rs2 = u2;
    flush = fl; mem_rvalid = rv; mem_rdata = rd;
  endtask

  task automatic check_now(input string tag);
    exp_t  e;
    string t;
    logic [3:0] obs_f;
    logic [3:0] exp_f;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    obs_f = {dec_stall, ex_bubble, is_ld_fwd_rs1, is_ld_fwd_rs2};
    exp_f = {e.stall, e.bubble, e.f1, e.f2};
    checks++;
    assert (obs_f === exp_f) else begin
      errors++;
      $error("FAIL %s flags(stall,bubble,f1,f2) got %b exp %b", t, obs_f, exp_f);
    end
    checks++;
    assert (ld_fwd_val === e.val) else begin
      errors++;
      $error("FAIL %s ld_fwd_val got %h exp %h", t, ld_fwd_val, e.val);
    end
    checks++;
    assert (stall_cnt === exp_cnt) else begin
      errors++;
      $error("FAIL %s stall_cnt got %h exp %h", t, stall_cnt, exp_cnt);
    end
    $display("step %-14s stall=%b bub=%b f1=%b f2=%b val=%h cnt=%0d (%s)",
             t, dec_stall, ex_bubble, is_ld_fwd_rs1, is_ld_fwd_rs2, ld_fwd_val, stall_cnt, tag);
  endtask

  // Inputs are already set; queue the expectation, sample mid-cycle, advance.
  task automatic cycle(input string tag, input logic st, input logic bub,
                       input logic f1, input logic f2, input logic [31:0] val);
    exp_t e;
    e = '{stall: st, bubble: bub, f1: f1, f2: f2, val: val};
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #2;
    check_now("cycle");
    @(posedge clk);
    if (st && !rst && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
    @(negedge clk);
  endtask

  task automatic idle_in();
    set_in(0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    @(negedge clk);
    cycle("reset", 0, 0, 0, 0, 32'h0);
    rst = 1'b0;

    // Single load to x5, response one cycle later.
    set_in(1, 1, 5'd5, 1, 5'd5, 5'd0, 1, 0, 0, 0, 32'h0);
    cycle("t1_detect", 1, 1, 0, 0, 32'h0);
    set_in(0, 0, 5'd0, 1, 5'd5, 5'd0, 1, 0, 0, 1, 32'hDEADBEEF);
    cycle("t1_wait", 1, 1, 0, 0, 32'h0);
    set_in(0, 0, 5'd0, 1, 5'd5, 5'd0, 1, 0, 0, 0, 32'h0);
    cycle("t1_fwd", 0, 0, 1, 0, 32'hDEADBEEF);
    idle_in();
    cycle("t1_idle", 0, 0, 0, 0, 32'hDEADBEEF);

    // No-hazard cases: x0 destination, unused rs2.
    set_in(1, 1, 5'd0, 1, 5'd0, 5'd0, 1, 1, 0, 0, 32'h0);
    cycle("t2_x0", 0, 0, 0, 0, 32'hDEADBEEF);
    set_in(1, 1, 5'd7, 1, 5'd1, 5'd7, 1, 0, 0, 0, 32'h0);
    cycle("t2_rs2_unused", 0, 0, 0, 0, 32'hDEADBEEF);
    set_in(1, 0, 5'd7, 1, 5'd7, 5'd7, 1, 1, 0, 0, 32'h0);
    cycle("t2_not_load", 0, 0, 0, 0, 32'hDEADBEEF);

    // Delayed response, both sources match x9.
    set_in(1, 1, 5'd9, 1, 5'd9, 5'd9, 1, 1, 0, 0, 32'h0);
    cycle("t3_detect", 1, 1, 0, 0, 32'hDEADBEEF);
    set_in(0, 0, 5'd0, 1, 5'd9, 5'd9, 1, 1, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) cycle("t3_wait", 1, 1, 0, 0, 32'hDEADBEEF);
    set_in(0, 0, 5'd0, 1, 5'd9, 5'd9, 1, 1, 0, 1, 32'h12345678);
    cycle("t3_resp", 1, 1, 0, 0, 32'hDEADBEEF);
    set_in(0, 0, 5'd0, 1, 5'd9, 5'd9, 1, 1, 0, 0, 32'h0);
    cycle("t3_fwd", 0, 0, 1, 1, 32'h12345678);
    idle_in();
    cycle("t3_idle", 0, 0, 0, 0, 32'h12345678);

    // Flush without response: drain the orphan.
    set_in(1, 1, 5'd3, 1, 5'd3, 5'd0, 1, 0, 0, 0, 32'h0);
    cycle("t4_detect", 1, 1, 0, 0, 32'h12345678);
    set_in(0, 0, 5'd0, 1, 5'd3, 5'd0, 1, 0, 1, 0, 32'h0);
    cycle("t4_flush", 1, 1, 0, 0, 32'h12345678);
    set_in(0, 0, 5'd0, 1, 5'd3, 5'd0, 1, 0, 1, 0, 32'h0);
    cycle("t4_drain", 1, 1, 0, 0, 32'h12345678);
    set_in(0, 0, 5'd0, 1, 5'd3, 5'd0, 1, 0, 0, 1, 32'h00000BAD);
    cycle("t4_drain_rsp", 1, 1, 0, 0, 32'h12345678);
    set_in(0, 0, 5'd0, 1, 5'd3, 5'd0, 1, 0, 0, 0, 32'h0);
    cycle("t4_idle", 0, 0, 0, 0, 32'h12345678);

    // Flush coinciding with the response: back to idle, nothing captured.
    set_in(1, 1, 5'd8, 1, 5'd0, 5'd8, 0, 1, 0, 0, 32'h0);
    cycle("t5_detect", 1, 1, 0, 0, 32'h12345678);
    set_in(0, 0, 5'd0, 1, 5'd0, 5'd8, 0, 1, 1, 1, 32'hCAFEF00D);
    cycle("t5_flush_rsp", 1, 1, 0, 0, 32'h12345678);
    set_in(0, 0, 5'd0, 1, 5'd0, 5'd8, 0, 1, 0, 0, 32'h0);
    cycle("t5_idle", 0, 0, 0, 0, 32'h12345678);

    // Saturation: preload near all-ones, then three stall cycles.
    idle_in();
    force dut.u_stall_cnt.cnt_reg = 32'hFFFF_FFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.u_stall_cnt.cnt_reg;
    exp_cnt = 32'hFFFF_FFFE;
    set_in(1, 1, 5'd4, 1, 5'd4, 5'd0, 1, 0, 0, 0, 32'h0);
    cycle("t6_detect", 1, 1, 0, 0, 32'h12345678);
    set_in(0, 0, 5'd0, 1, 5'd4, 5'd0, 1, 0, 0, 0, 32'h0);
    cycle("t6_wait", 1, 1, 0, 0, 32'h12345678);
    set_in(0, 0, 5'd0, 1, 5'd4, 5'd0, 1, 0, 0, 1, 32'h0000_0044);
    cycle("t6_resp", 1, 1, 0, 0, 32'h12345678);
    set_in(0, 0, 5'd0, 1, 5'd4, 5'd0, 1, 0, 0, 0, 32'h0);
    cycle("t6_fwd_sat", 0, 0, 1, 0, 32'h0000_0044);
    idle_in();
    cycle("t6_hold_sat", 0, 0, 0, 0, 32'h0000_0044);

    // Asynchronous reset in the middle of WAIT.
    set_in(1, 1, 5'd6, 1, 5'd6, 5'd0, 1, 0, 0, 0, 32'h0);
    cycle("t7_detect", 1, 1, 0, 0, 32'h0000_0044);
    set_in(0, 0, 5'd0, 1, 5'd6, 5'd0, 1, 0, 0, 0, 32'h0);
    cycle("t7_wait", 1, 1, 0, 0, 32'h0000_0044);
    #2;
    rst = 1'b1;
    #1;
    exp_cnt = '0;
    exp_q.push_back('{stall: 1'b0, bubble: 1'b0, f1: 1'b0, f2: 1'b0, val: 32'h0});
    tag_q.push_back("t7_async_rst");
    check_now("async");
    @(negedge clk);
    rst = 1'b0;
    set_in(0, 0, 5'd0, 1, 5'd6, 5'd0, 1, 0, 0, 1, 32'h7777_7777);
    cycle("t7_late_rsp", 0, 0, 0, 0, 32'h0);
    set_in(0, 0, 5'd0, 1, 5'd6, 5'd0, 1, 0, 0, 0, 32'h0);
    cycle("t7_no_fwd", 0, 0, 0, 0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL watchdog timeout got running exp finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
